// File: rtl/sprite_line_render.sv
// Sprite line renderer: captures the per-line sprite slot set at line start,
// then emits one registered RGB565 sprite pixel per pixel strobe across the
// active line. The lowest-index opaque slot wins each pixel.
module sprite_line_render #(
  parameter int          MAX_ACTIVE  = 8,
  parameter int          H_ACTIVE    = 640,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic                      pix_en,
  input  logic                      slot_ready,
  input  logic [MAX_ACTIVE-1:0]     slot_valid,
  input  logic [MAX_ACTIVE*10-1:0]  slot_counter_init,
  input  logic [MAX_ACTIVE*256-1:0] slot_pixel_row,
  input  logic [MAX_ACTIVE*2-1:0]   slot_priority,
  output logic                      load_ack,
  output logic                      pix_valid,
  output logic [15:0]               pix_color,
  output logic [1:0]                pix_priority,
  output logic                      line_done,
  output logic                      line_miss
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    hcnt_q;
  logic          step;
  logic          last_px;

  logic [MAX_ACTIVE-1:0] valid_sh;
  logic [255:0]          row_sh  [MAX_ACTIVE];
  logic [1:0]            prio_sh [MAX_ACTIVE];
  logic [9:0]            cnt_q   [MAX_ACTIVE];
  logic [4:0]            emit_q  [MAX_ACTIVE];

  logic [MAX_ACTIVE-1:0] cand_vld;
  logic [15:0]           cand_col [MAX_ACTIVE];
  logic                  win_vld;
  logic [15:0]           win_col;
  logic [1:0]            win_pri;

  logic                  pix_vld_p1;
  logic [15:0]           pix_col_p1;
  logic [1:0]            pix_pri_p1;

  // Pixel position counter stops at the line width so late strobes cannot wrap it.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'(H_ACTIVE)) ? v : v + 10'd1;
  endfunction

  // A strobe counts only inside the active line; a same-cycle line_start takes precedence.
  assign step    = (state_q == ACTIVE) && pix_en && !line_start;
  assign last_px = step && (hcnt_q == 10'(H_ACTIVE - 1));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; any line_start restarts the line from pixel 0
  always_comb begin
    state_d   = state_q;
    line_done = 1'b0;
    case (state_q)
      IDLE:    if (line_start) state_d = ACTIVE;
      ACTIVE:  if (line_start) state_d = ACTIVE;
               else if (last_px) state_d = DONE;
      DONE: begin
        line_done = 1'b1;
        state_d   = line_start ? ACTIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow slot data; qualified by valid_sh so it needs no reset
  always_ff @(posedge clk) begin
    if (line_start && slot_ready) begin
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        row_sh[i]  <= slot_pixel_row[i*256 +: 256];
        prio_sh[i] <= slot_priority[i*2 +: 2];
      end
    end
  end

  // Capture control, per-slot column countdown and emitted-pixel index, line position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sh  <= '0;
      hcnt_q    <= '0;
      load_ack  <= 1'b0;
      line_miss <= 1'b0;
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        cnt_q[i]  <= '0;
        emit_q[i] <= '0;
      end
    end else begin
      load_ack <= line_start && slot_ready;
      if (line_start) begin
        hcnt_q   <= '0;
        valid_sh <= slot_ready ? slot_valid : '0;
        if (!slot_ready) line_miss <= 1'b1;
        for (int i = 0; i < MAX_ACTIVE; i++) begin
          cnt_q[i]  <= slot_counter_init[i*10 +: 10];
          emit_q[i] <= '0;
        end
      end else if (step) begin
        hcnt_q <= sat_inc(hcnt_q);
        for (int i = 0; i < MAX_ACTIVE; i++) begin
          if (cnt_q[i] != 10'd0)  cnt_q[i]  <= cnt_q[i] - 10'd1;
          else if (!emit_q[i][4]) emit_q[i] <= emit_q[i] + 5'd1;
        end
      end
    end
  end

  // Candidate pixels and lowest-index opaque winner for the current strobe
  always_comb begin
    win_vld = 1'b0;
    win_col = '0;
    win_pri = '0;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      cand_vld[i] = valid_sh[i] && (cnt_q[i] == 10'd0) && !emit_q[i][4];
      cand_col[i] = row_sh[i][{emit_q[i][3:0], 4'h0} +: 16];
    end
    for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
      if (cand_vld[i] && (cand_col[i] != TRANSPARENT)) begin
        win_vld = 1'b1;
        win_col = cand_col[i];
        win_pri = prio_sh[i];
      end
    end
  end

  // ---- stage p1: registered pixel output, held between strobes, zero outside the line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_vld_p1 <= 1'b0;
      pix_col_p1 <= '0;
      pix_pri_p1 <= '0;
    end else if (line_start || (state_q != ACTIVE)) begin
      pix_vld_p1 <= 1'b0;
      pix_col_p1 <= '0;
      pix_pri_p1 <= '0;
    end else if (step) begin
      pix_vld_p1 <= win_vld;
      pix_col_p1 <= win_col;
      pix_pri_p1 <= win_pri;
    end
  end

  assign pix_valid    = pix_vld_p1;
  assign pix_color    = pix_col_p1;
  assign pix_priority = pix_pri_p1;

endmodule

// File: tb/tb_sprite_line_render.sv
// Bench for sprite_line_render: stimulus pushes the expected pixel for every
// counted strobe into a queue; a monitor pops and compares one clock later.
`timescale 1ns/1ps
module tb_sprite_line_render;

  localparam int N = 8;
  localparam int H = 640;
  localparam logic [15:0] KEY = 16'hF81F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_start = 1'b0;
  logic pix_en = 1'b0;
  logic slot_ready = 1'b0;
  logic [N-1:0]     slot_valid;
  logic [N*10-1:0]  slot_counter_init;
  logic [N*256-1:0] slot_pixel_row;
  logic [N*2-1:0]   slot_priority;
  logic load_ack, pix_valid, line_done, line_miss;
  logic [15:0] pix_color;
  logic [1:0]  pix_priority;

  logic [N-1:0] t_vld;
  logic [9:0]   t_col [N];
  logic [15:0]  t_px  [N][16];
  logic [1:0]   t_pri [N];
  logic         m_ready = 1'b0;
  logic         chk = 1'b0;
  logic [18:0]  exp_q [$];
  int total = 0;
  int bad = 0;

  sprite_line_render dut (
    .clk(clk), .reset(reset), .line_start(line_start), .pix_en(pix_en),
    .slot_ready(slot_ready), .slot_valid(slot_valid),
    .slot_counter_init(slot_counter_init), .slot_pixel_row(slot_pixel_row),
    .slot_priority(slot_priority), .load_ack(load_ack), .pix_valid(pix_valid),
    .pix_color(pix_color), .pix_priority(pix_priority), .line_done(line_done),
    .line_miss(line_miss)
  );

  always #5 clk = ~clk;

  always_comb begin
    slot_valid        = t_vld;
    slot_counter_init = '0;
    slot_pixel_row    = '0;
    slot_priority     = '0;
    for (int i = 0; i < N; i++) begin
      slot_counter_init[i*10 +: 10] = t_col[i];
      slot_priority[i*2 +: 2]       = t_pri[i];
      for (int k = 0; k < 16; k++) slot_pixel_row[i*256 + k*16 +: 16] = t_px[i][k];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: slot i covers columns col..col+15; lowest opaque index wins
  function automatic logic [18:0] model(input int h);
    logic [18:0] v = '0;
    for (int i = N - 1; i >= 0; i--) begin
      int c = int'(t_col[i]);
      if (m_ready && t_vld[i] && h >= c && h < c + 16 && t_px[i][h-c] != KEY)
        v = {1'b1, t_px[i][h-c], t_pri[i]};
    end
    return v;
  endfunction

  task automatic clear_slots();
    t_vld = '0;
    for (int i = 0; i < N; i++) begin
      t_col[i] = 10'd0;
      t_pri[i] = 2'd0;
      for (int k = 0; k < 16; k++) t_px[i][k] = 16'h0000;
    end
  endtask

  task automatic start_line(input logic rdy, input logic with_pix);
    @(negedge clk);
    slot_ready = rdy;
    line_start = 1'b1;
    pix_en     = with_pix;
    chk        = 1'b0;
    m_ready    = rdy;
    @(negedge clk);
    line_start = 1'b0;
    pix_en     = 1'b0;
    check("load_ack", {31'd0, load_ack}, {31'd0, rdy});
  endtask

  task automatic run_line(input int n, input bit full);
    for (int h = 0; h < n; h++) begin
      @(negedge clk);
      pix_en = 1'b1;
      chk    = 1'b1;
      exp_q.push_back(model(h));
    end
    if (full) begin
      @(negedge clk);
      pix_en = 1'b0;
      chk    = 1'b0;
      check("line_done_pulse", {31'd0, line_done}, 32'd1);
      @(negedge clk);
      pix_en = 1'b1;
      check("line_done_end", {31'd0, line_done}, 32'd0);
      check("idle_pix_valid", {31'd0, pix_valid}, 32'd0);
      @(negedge clk);
      pix_en = 1'b0;
      check("idle_strobe_ignored", {31'd0, pix_valid}, 32'd0);
    end
  endtask

  // Monitor: every counted strobe yields one output one clock later
  initial begin
    logic s;
    logic [18:0] e;
    forever begin
      @(posedge clk);
      s = chk;
      @(negedge clk);
      if (s) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {13'd0, pix_valid, pix_color, pix_priority}, {13'd0, e});
        end
      end
    end
  end

  initial begin
    clear_slots();
    repeat (3) @(negedge clk);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_outputs", {11'd0, load_ack, pix_color, pix_priority, line_done, line_miss}, 32'd0);
    reset = 1'b0;

    // Single slot at column 100 with an incrementing row
    t_vld[0] = 1'b1; t_col[0] = 10'd100; t_pri[0] = 2'd2;
    for (int k = 0; k < 16; k++) t_px[0][k] = 16'h1000 + 16'(k);
    start_line(1'b1, 1'b0);
    run_line(H, 1'b1);
    check("no_miss_yet", {31'd0, line_miss}, 32'd0);

    // Overlap: slot0 wins except where its pixel is the colour key
    clear_slots();
    t_vld[0] = 1'b1; t_col[0] = 10'd50; t_pri[0] = 2'd1;
    t_vld[3] = 1'b1; t_col[3] = 10'd50; t_pri[3] = 2'd3;
    for (int k = 0; k < 16; k++) begin t_px[0][k] = 16'h07E0; t_px[3][k] = 16'h001F; end
    t_px[0][2] = KEY;
    start_line(1'b1, 1'b0);
    run_line(H, 1'b1);

    // Right-edge clipping and an off-screen slot
    clear_slots();
    t_vld[1] = 1'b1; t_col[1] = 10'd630; t_pri[1] = 2'd1;
    t_vld[2] = 1'b1; t_col[2] = 10'd640; t_pri[2] = 2'd2;
    for (int k = 0; k < 16; k++) begin t_px[1][k] = 16'h2000 + 16'(k); t_px[2][k] = 16'h3333; end
    start_line(1'b1, 1'b0);
    run_line(H, 1'b1);

    // Slot set not ready: line renders transparent, miss latches
    start_line(1'b0, 1'b0);
    check("line_miss_set", {31'd0, line_miss}, 32'd1);
    run_line(H, 1'b1);
    check("line_miss_sticky", {31'd0, line_miss}, 32'd1);

    // Restart mid-line with a strobe in the line_start cycle
    clear_slots();
    t_vld[4] = 1'b1; t_col[4] = 10'd195; t_pri[4] = 2'd1;
    for (int k = 0; k < 16; k++) t_px[4][k] = 16'h4400 + 16'(k);
    start_line(1'b1, 1'b0);
    run_line(200, 1'b0);
    t_col[4] = 10'd0;
    start_line(1'b1, 1'b1);
    run_line(H, 1'b1);

    // Reset mid-line at h=300 while a sprite pixel is showing
    clear_slots();
    t_vld[0] = 1'b1; t_col[0] = 10'd290; t_pri[0] = 2'd3;
    for (int k = 0; k < 16; k++) t_px[0][k] = 16'h5500 + 16'(k);
    start_line(1'b1, 1'b0);
    run_line(300, 1'b0);
    @(negedge clk);
    pix_en = 1'b0;
    chk    = 1'b0;
    #1 reset = 1'b1;
    #1 check("async_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_outputs", {11'd0, load_ack, pix_color, pix_priority, line_done, line_miss}, 32'd0);
    pix_en = 1'b1;
    repeat (3) @(negedge clk);
    pix_en = 1'b0;
    check("rst_idle_ignores_pix", {31'd0, pix_valid}, 32'd0);

    // Fresh line after reset starts from pixel 0
    t_col[0] = 10'd0;
    start_line(1'b1, 1'b0);
    run_line(H, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
